// File: rtl/kianv_io_fabric.sv
// kianv_io_fabric: registered-decode CPU-to-slave IO interconnect with timeout faults and a guard cycle
module kianv_io_fabric #(
  parameter int                       NUM_SLAVES     = 8,
  parameter logic [NUM_SLAVES*32-1:0] SLAVE_BASE     = {NUM_SLAVES{32'h0}},
  parameter logic [NUM_SLAVES*32-1:0] SLAVE_MASK     = {NUM_SLAVES{32'hFFFF_FFFC}},
  parameter int                       TIMEOUT_CYCLES = 255,
  parameter logic [31:0]              ERR_RDATA      = 32'h0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cpu_valid,
  input  logic [31:0]              cpu_addr,
  input  logic [31:0]              cpu_wdata,
  input  logic [3:0]               cpu_wstrb,
  output logic                     cpu_ready,
  output logic [31:0]              cpu_rdata,
  output logic                     cpu_fault,
  output logic [NUM_SLAVES-1:0]    s_valid,
  output logic [31:0]              s_addr,
  output logic [31:0]              s_wdata,
  output logic [3:0]               s_wstrb,
  input  logic [NUM_SLAVES*32-1:0] s_rdata,
  input  logic [NUM_SLAVES-1:0]    s_ready,
  output logic [15:0]              fault_count,
  output logic [31:0]              last_fault_addr
);
  localparam int IW = NUM_SLAVES > 1 ? $clog2(NUM_SLAVES) : 1;
  typedef enum logic [1:0] {IDLE, WAIT, RESP, GAP} state_t;
  state_t state, state_nx;
  logic [IW-1:0] idx, dec_idx;
  logic dec_hit, sel_ready, expire, accept, to_fault, fault_q;
  logic [15:0] cnt;
  logic [31:0] rdata_q;
  always_comb begin
    dec_hit = 1'b0;
    dec_idx = '0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--)
      if ((cpu_addr & SLAVE_MASK[32*i+:32]) == SLAVE_BASE[32*i+:32]) begin
        dec_hit = 1'b1;
        dec_idx = IW'(i);
      end
  end
  assign sel_ready = s_ready[idx];
  assign expire    = cnt == 16'(TIMEOUT_CYCLES - 1);
  assign accept    = state == IDLE && cpu_valid;
  // a ready in the expiry cycle takes precedence over the timeout
  assign to_fault  = (accept && !dec_hit) || (state == WAIT && !sel_ready && expire);
  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else     state <= state_nx;
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (cpu_valid) state_nx = dec_hit ? WAIT : RESP;
      WAIT:    if (sel_ready || expire) state_nx = RESP;
      RESP:    state_nx = GAP;
      default: state_nx = IDLE;
    endcase
  end
  always_comb begin
    s_valid   = state == WAIT ? NUM_SLAVES'(1) << idx : '0;
    cpu_ready = state == RESP;
    cpu_fault = cpu_ready && fault_q;
    cpu_rdata = !cpu_ready ? 32'h0 : fault_q ? ERR_RDATA : rdata_q;
  end
  always_ff @(posedge clk)
    if (rst) begin
      s_addr          <= '0;
      s_wdata         <= '0;
      s_wstrb         <= '0;
      idx             <= '0;
      cnt             <= '0;
      fault_q         <= 1'b0;
      rdata_q         <= '0;
      fault_count     <= '0;
      last_fault_addr <= '0;
    end else begin
      if (accept) begin
        s_addr  <= cpu_addr;
        s_wdata <= cpu_wdata;
        s_wstrb <= cpu_wstrb;
        idx     <= dec_idx;
        cnt     <= '0;
        fault_q <= !dec_hit;
      end
      if (state == WAIT) begin
        cnt     <= cnt + 16'd1;
        fault_q <= !sel_ready && expire;
        if (sel_ready) rdata_q <= s_rdata[32*idx+:32];
      end
      if (to_fault) begin
        fault_count     <= fault_count + 16'(fault_count != 16'hFFFF);
        last_fault_addr <= accept ? cpu_addr : s_addr;
      end
    end
endmodule

// File: tb/tb_kianv_io_fabric.sv
// tb_kianv_io_fabric: directed scoreboard bench for the IO fabric decode, timeout, guard and reset paths
module tb_kianv_io_fabric;
  localparam int N = 4;
  localparam logic [31:0] ERR = 32'hBAD0_0BAD;
  logic clk = 1'b0, rst = 1'b1, cpu_valid = 1'b0;
  logic [31:0] cpu_addr = '0, cpu_wdata = '0;
  logic [3:0] cpu_wstrb = '0;
  logic cpu_ready, cpu_fault;
  logic [31:0] cpu_rdata, s_addr, s_wdata, last_fault_addr;
  logic [N-1:0] s_valid, s_ready = '0;
  logic [3:0] s_wstrb;
  logic [N*32-1:0] s_rdata = '0;
  logic [15:0] fault_count;
  typedef struct packed {logic [31:0] d; logic f;} exp_t;
  exp_t q[$];
  int vec = 0, errs = 0;

  kianv_io_fabric #(
    .NUM_SLAVES(N),
    .SLAVE_BASE({32'h0000_0000, 32'h1000_0000, 32'h3000_0000, 32'h0000_0000}),
    .SLAVE_MASK({N{32'hFFFF_FFFC}}),
    .TIMEOUT_CYCLES(4),
    .ERR_RDATA(ERR)
  ) dut (
    .clk(clk), .rst(rst), .cpu_valid(cpu_valid), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_wstrb(cpu_wstrb), .cpu_ready(cpu_ready), .cpu_rdata(cpu_rdata), .cpu_fault(cpu_fault),
    .s_valid(s_valid), .s_addr(s_addr), .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_rdata(s_rdata),
    .s_ready(s_ready), .fault_count(fault_count), .last_fault_addr(last_fault_addr)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic resp(input string tag);
    exp_t e;
    chk({tag, ".ready"}, 32'(cpu_ready), 32'd1);
    if (q.size() == 0) begin
      vec++;
      errs++;
      $error("FAIL %s.scoreboard observed empty expected entry", tag);
    end else begin
      e = q.pop_front();
      chk({tag, ".rdata"}, cpu_rdata, e.d);
      chk({tag, ".fault"}, 32'(cpu_fault), 32'(e.f));
    end
  endtask

  task automatic idle_chk(input string tag);
    chk({tag, ".noready"}, 32'(cpu_ready), 32'd0);
    chk({tag, ".rdata0"}, cpu_rdata, 32'd0);
  endtask

  initial begin
    tick();
    tick();
    chk("rst.s_valid", 32'(s_valid), 32'd0);
    idle_chk("rst");
    chk("rst.fcnt", 32'(fault_count), 32'd0);
    chk("rst.faddr", last_fault_addr, 32'd0);
    rst = 1'b0;
    tick();

    // read of slave 2, ready in first WAIT cycle
    cpu_valid = 1'b1; cpu_addr = 32'h1000_0000; cpu_wstrb = 4'h0;
    q.push_back('{32'hDEAD_BEEF, 1'b0});
    tick();
    chk("rd.s_valid", 32'(s_valid), 32'b0100);
    chk("rd.s_addr", s_addr, 32'h1000_0000);
    idle_chk("rd.wait");
    cpu_valid = 1'b0; s_ready[2] = 1'b1; s_rdata[64+:32] = 32'hDEAD_BEEF;
    tick();
    s_ready = '0;
    chk("rd.s_valid_drop", 32'(s_valid), 32'd0);
    resp("rd");
    tick();
    idle_chk("rd.gap");
    tick();

    // write to address 0 (slaves 0 and 3 overlap, 0 wins), valid held high through GAP
    cpu_valid = 1'b1; cpu_addr = 32'h0; cpu_wdata = 32'hAB; cpu_wstrb = 4'b0001;
    q.push_back('{32'h1234_5678, 1'b0});
    tick();
    chk("wr.s_valid", 32'(s_valid), 32'b0001);
    cpu_wdata = 32'hFF; cpu_addr = 32'h1000_0000;
    tick();
    chk("wr.s_valid2", 32'(s_valid), 32'b0001);
    chk("wr.s_wdata", s_wdata, 32'hAB);
    chk("wr.s_wstrb", 32'(s_wstrb), 32'b0001);
    s_ready[0] = 1'b1; s_rdata[0+:32] = 32'h1234_5678;
    tick();
    s_ready = '0;
    resp("wr");
    chk("wr.resp_s_valid", 32'(s_valid), 32'd0);
    tick();
    chk("wr.gap_s_valid", 32'(s_valid), 32'd0);
    idle_chk("wr.gap");
    tick();
    cpu_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("wr.no_reissue", 32'(s_valid), 32'd0);
      idle_chk("wr.after");
    end

    // unmapped read
    cpu_valid = 1'b1; cpu_addr = 32'h2000_0000; cpu_wstrb = 4'h0;
    q.push_back('{ERR, 1'b1});
    tick();
    cpu_valid = 1'b0;
    chk("um.s_valid", 32'(s_valid), 32'd0);
    resp("um");
    tick();
    chk("um.fcnt", 32'(fault_count), 32'd1);
    chk("um.faddr", last_fault_addr, 32'h2000_0000);
    idle_chk("um.gap");
    tick();

    // silent slave 1 times out; stray readies are ignored
    cpu_valid = 1'b1; cpu_addr = 32'h3000_0000;
    q.push_back('{ERR, 1'b1});
    tick();
    cpu_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("to.s_valid", 32'(s_valid), 32'b0010);
      idle_chk("to.wait");
      s_ready[2] = (i == 1); s_rdata[64+:32] = 32'h5555_5555;
      tick();
    end
    s_ready = '0;
    chk("to.s_valid_drop", 32'(s_valid), 32'd0);
    resp("to");
    tick();
    s_ready[1] = 1'b1; s_rdata[32+:32] = 32'h7777_7777;
    idle_chk("to.gap");
    tick();
    s_ready = '0;
    idle_chk("to.late");
    chk("to.fcnt", 32'(fault_count), 32'd2);
    chk("to.faddr", last_fault_addr, 32'h3000_0000);
    tick();
    idle_chk("to.late2");
    chk("to.late_s_valid", 32'(s_valid), 32'd0);

    // ready in the expiry cycle wins
    cpu_valid = 1'b1; cpu_addr = 32'h3000_0002;
    q.push_back('{32'hCAFE_F00D, 1'b0});
    tick();
    cpu_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("ex.s_valid", 32'(s_valid), 32'b0010);
      s_ready[1] = (i == 3); s_rdata[32+:32] = 32'hCAFE_F00D;
      tick();
    end
    s_ready = '0;
    resp("ex");
    tick();
    chk("ex.fcnt", 32'(fault_count), 32'd2);
    tick();

    // reset during WAIT, then a normal request
    cpu_valid = 1'b1; cpu_addr = 32'h1000_0003;
    tick();
    cpu_valid = 1'b0;
    chk("rw.s_valid", 32'(s_valid), 32'b0100);
    rst = 1'b1;
    tick();
    chk("rw.s_valid_rst", 32'(s_valid), 32'd0);
    idle_chk("rw.rst");
    chk("rw.fcnt", 32'(fault_count), 32'd0);
    chk("rw.faddr", last_fault_addr, 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      idle_chk("rw.after");
      chk("rw.after_s_valid", 32'(s_valid), 32'd0);
    end
    cpu_valid = 1'b1; cpu_addr = 32'h1000_0000;
    q.push_back('{32'h0BAD_F00D, 1'b0});
    tick();
    cpu_valid = 1'b0;
    chk("rn.s_valid", 32'(s_valid), 32'b0100);
    s_ready[2] = 1'b1; s_rdata[64+:32] = 32'h0BAD_F00D;
    tick();
    s_ready = '0;
    resp("rn");
    tick();
    idle_chk("rn.gap");
    chk("sb.drained", 32'(q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule
